// File: rtl/sram_cfg_pkg.sv
// Shared types, widths and default register map for the SRAM config APB loader.
package sram_cfg_pkg;

  localparam int unsigned SRAM_AW = 16;
  localparam int unsigned SRAM_DW = 23;
  localparam int unsigned APB_AW  = 32;
  localparam int unsigned APB_DW  = 32;

  localparam logic [APB_AW-1:0] DEF_IDX_OFS = 32'h0000_0000;
  localparam logic [APB_AW-1:0] DEF_DAT_OFS = 32'h0000_0004;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_WRV = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_SLV = 2'b01,
    ERR_TMO = 2'b10,
    ERR_MIS = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IDX_SETUP  = 3'd1,
    IDX_ACCESS = 3'd2,
    DAT_SETUP  = 3'd3,
    DAT_ACCESS = 3'd4,
    VFY_SETUP  = 3'd5,
    VFY_ACCESS = 3'd6,
    RESP       = 3'd7
  } state_e;

  // Request fields that must outlive the handshake (index lives in PWDATA).
  typedef struct packed {
    op_e                op;
    logic [SRAM_DW-1:0] data;
  } req_t;

endpackage

// File: rtl/apb_xfer_timer.sv
// Counts ACCESS-phase wait cycles of one APB transfer and flags the last allowed one.
module apb_xfer_timer #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter: cleared per transfer, advanced on each stalled ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire_c = (r_cnt == LAST);

endmodule

// File: rtl/sram_apb_loader.sv
// APB initiator that writes / reads / write-verifies SRAM mapping-table entries.
module sram_apb_loader
  import sram_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] IDX_OFS     = DEF_IDX_OFS,
  parameter logic [31:0] DAT_OFS     = DEF_DAT_OFS,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [SRAM_AW-1:0] req_index,
  input  logic [SRAM_DW-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [SRAM_DW-1:0] rsp_rdata,
  output logic [1:0]         rsp_err,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [APB_AW-1:0]  PADDR,
  output logic [APB_DW-1:0]  PWDATA,
  input  logic [APB_DW-1:0]  PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam logic [APB_AW-1:0] IDX_ADDR = BASE_ADDR + IDX_OFS;
  localparam logic [APB_AW-1:0] DAT_ADDR = BASE_ADDR + DAT_OFS;

  state_e             r_state;
  state_e             w_next_state;
  state_e             w_acc_next;
  req_t               r_req;

  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [SRAM_DW-1:0] r_rsp_rdata;
  err_e               r_rsp_err;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [APB_AW-1:0]  r_paddr;
  logic [APB_DW-1:0]  r_pwdata;

  logic [SRAM_DW-1:0] w_rsp_rdata;
  err_e               w_rsp_err;
  logic               w_pwrite;
  logic [APB_AW-1:0]  w_paddr;
  logic [APB_DW-1:0]  w_pwdata;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic               w_tmr_expire_c;
  logic               w_unused_prdata;

  assign w_unused_prdata = ^PRDATA[APB_DW-1:SRAM_DW];

  apb_xfer_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expire_c(w_tmr_expire_c)
  );

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Successor of each ACCESS state on a clean (PREADY, no PSLVERR) completion.
  always_comb begin
    w_acc_next = RESP;
    unique case (r_state)
      IDX_ACCESS: w_acc_next = DAT_SETUP;
      DAT_ACCESS: w_acc_next = (r_req.op == OP_WRV) ? VFY_SETUP : RESP;
      default:    w_acc_next = RESP;
    endcase
  end

  // Next state, response payload and timer control.
  always_comb begin
    w_next_state = r_state;
    w_rsp_rdata  = r_rsp_rdata;
    w_rsp_err    = r_rsp_err;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_rsp_rdata = '0;
          if (req_op == OP_RSV) begin
            w_next_state = RESP;
            w_rsp_err    = ERR_MIS;
          end else begin
            w_next_state = IDX_SETUP;
            w_rsp_err    = ERR_OK;
          end
        end
      end
      IDX_SETUP: begin
        w_next_state = IDX_ACCESS;
        w_tmr_clr    = 1'b1;
      end
      DAT_SETUP: begin
        w_next_state = DAT_ACCESS;
        w_tmr_clr    = 1'b1;
      end
      VFY_SETUP: begin
        w_next_state = VFY_ACCESS;
        w_tmr_clr    = 1'b1;
      end
      IDX_ACCESS, DAT_ACCESS, VFY_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            w_next_state = RESP;
            w_rsp_err    = ERR_SLV;
          end else begin
            w_next_state = w_acc_next;
            if (((r_state == DAT_ACCESS) && (r_req.op == OP_RD)) || (r_state == VFY_ACCESS)) begin
              w_rsp_rdata = PRDATA[SRAM_DW-1:0];
            end
            if ((r_state == VFY_ACCESS) && (PRDATA[SRAM_DW-1:0] != r_req.data)) begin
              w_rsp_err = ERR_MIS;
            end
          end
        end else if (w_tmr_expire_c) begin
          w_next_state = RESP;
          w_rsp_err    = ERR_TMO;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next_state = IDLE;
        end
      end
    endcase
  end

  // APB address/direction/data, loaded once when a SETUP phase is entered.
  always_comb begin
    w_paddr  = r_paddr;
    w_pwrite = r_pwrite;
    w_pwdata = r_pwdata;
    if (w_next_state != r_state) begin
      case (w_next_state)
        IDX_SETUP: begin
          w_paddr  = IDX_ADDR;
          w_pwrite = 1'b1;
          w_pwdata = APB_DW'(req_index);
        end
        DAT_SETUP: begin
          w_paddr  = DAT_ADDR;
          w_pwrite = (r_req.op != OP_RD);
          w_pwdata = APB_DW'(r_req.data);
        end
        VFY_SETUP: begin
          w_paddr  = DAT_ADDR;
          w_pwrite = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and captured request.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_req       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      if (req_valid && r_req_ready) begin
        r_req <= '{op: op_e'(req_op), data: req_data};
      end
      r_req_ready <= (w_next_state == IDLE);
      r_rsp_valid <= (w_next_state == RESP);
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_psel      <= (w_next_state != IDLE) && (w_next_state != RESP);
      r_penable   <= (w_next_state == IDX_ACCESS) || (w_next_state == DAT_ACCESS) ||
                     (w_next_state == VFY_ACCESS);
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_sram_apb_loader.sv
// Bench for sram_apb_loader: behavioural APB slave plus a transaction-level reference model.
module tb_sram_apb_loader;

  localparam int          TMO   = 4;
  localparam logic [31:0] IDX_A = 32'h0000_0000;
  localparam logic [31:0] DAT_A = 32'h0000_0004;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_index;
  logic [22:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [22:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_total = 0;
  int n_pass  = 0;

  // Slave knobs and observation state.
  int          g_waits = 0;
  int          g_err_x = -1;
  logic [22:0] g_corr  = '0;
  int          s_acc = 0;
  int          s_xn  = 0;
  int          acc_total = 0;
  logic [15:0] s_idx = '0;
  logic [22:0] s_mem[int];
  logic [55:0] log_q[$];

  // Reference model's view of the table.
  logic [22:0] mem_ref[int];

  sram_apb_loader #(
    .BASE_ADDR  (32'h0000_0000),
    .IDX_OFS    (32'h0),
    .DAT_OFS    (32'h4),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_index(req_index),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Slave response: PREADY after g_waits stalled ACCESS cycles, PSLVERR on transfer g_err_x.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      acc_total++;
      if (s_acc >= g_waits) begin
        PREADY  = 1'b1;
        PSLVERR = (s_xn == g_err_x);
        PRDATA  = PWRITE ? 32'h0 :
                  {9'h0, (s_mem.exists(int'(s_idx)) ? s_mem[int'(s_idx)] : 23'h0) ^ g_corr};
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      s_acc++;
    end else begin
      s_acc   = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
    end
  end

  // Slave commit and transfer log: {pwrite, paddr, data[22:0]} per completed transfer.
  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      log_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA[22:0] : PRDATA[22:0]});
      if (!PSLVERR && PWRITE) begin
        if (PADDR == IDX_A) s_idx = PWDATA[15:0];
        else if (PADDR == DAT_A) s_mem[int'(s_idx)] = PWDATA[22:0];
      end
      s_xn++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [22:0] ref_rd(input logic [15:0] idx);
    return mem_ref.exists(int'(idx)) ? mem_ref[int'(idx)] : 23'h0;
  endfunction

  // One request: predict the outcome, drive it, then compare the response and APB trace.
  task automatic run_req(input logic [1:0] op, input logic [15:0] idx, input logic [22:0] data,
                         input int waits, input int err_x, input logic [22:0] corr,
                         input int hold);
    logic [55:0] plan[$];
    logic [55:0] exp_q[$];
    logic [55:0] x;
    logic [1:0]  exp_err;
    logic [22:0] exp_rd;
    logic        rd_defined;
    int          exp_lat;
    int          exp_acc;
    int          lat;
    int          n;

    exp_err = 2'b00;
    exp_rd  = '0;
    exp_lat = 1;
    exp_acc = 0;
    if (op == 2'b11) begin
      exp_err = 2'b11;
    end else begin
      plan.push_back({1'b1, IDX_A, 7'h0, idx});
      plan.push_back({(op != 2'b01), DAT_A, data});
      if (op == 2'b10) plan.push_back({1'b0, DAT_A, 23'h0});
    end
    for (int k = 0; k < plan.size(); k++) begin
      x = plan[k];
      if (waits >= TMO) begin
        exp_lat += 1 + TMO;
        exp_acc += TMO;
        exp_err  = 2'b10;
        break;
      end
      exp_lat += 2 + waits;
      exp_acc += waits + 1;
      if (!x[55]) x[22:0] = ref_rd(idx) ^ corr;
      exp_q.push_back(x);
      if (k == err_x) begin
        exp_err = 2'b01;
        break;
      end
      if (x[55] && (x[54:23] == DAT_A)) mem_ref[int'(idx)] = data;
      if (!x[55]) exp_rd = x[22:0];
    end
    if ((op == 2'b10) && (exp_err == 2'b00) && (exp_rd != data)) exp_err = 2'b11;
    rd_defined = (exp_err == 2'b00) || (exp_err == 2'b11);

    log_q.delete();
    s_xn      = 0;
    acc_total = 0;
    g_waits   = waits;
    g_err_x   = err_x;
    g_corr    = corr;

    @(negedge PCLK);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    @(negedge PCLK);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(negedge PCLK);
      lat++;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    if (rd_defined) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("psel_in_resp", 64'({PSEL, PENABLE}), 64'd0);
    chk("access_cycles", 64'(acc_total), 64'(exp_acc));
    chk("xfer_count", 64'(log_q.size()), 64'(exp_q.size()));
    for (int k = 0; (k < exp_q.size()) && (k < log_q.size()); k++) begin
      chk("xfer", 64'(log_q[k]), 64'(exp_q[k]));
    end
    repeat (hold) begin
      @(negedge PCLK);
      chk("hold_state", 64'({rsp_valid, req_ready, rsp_err}), 64'({1'b1, 1'b0, exp_err}));
      if (rd_defined) chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("after_rsp", 64'({rsp_valid, req_ready}), 64'd1);
  endtask

  initial begin
    int n_rsp;
    int r;
    int waits;
    int err_x;
    logic [1:0]  op;
    logic [22:0] corr;

    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_index = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset values.
    repeat (3) @(negedge PCLK);
    chk("rst_apb_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Directed cases.
    run_req(2'b00, 16'h1234, 23'h5A5A5A, 0, -1, 23'h0, 0);
    run_req(2'b01, 16'hFFFF, 23'h0, 0, -1, 23'h7FFFFF, 0);
    run_req(2'b10, 16'h0042, 23'h000001, 0, -1, 23'h000002, 0);
    run_req(2'b00, 16'h0100, 23'h000123, 0, 0, 23'h0, 0);
    run_req(2'b01, 16'h1234, 23'h0, TMO, -1, 23'h0, 0);
    run_req(2'b01, 16'h1234, 23'h0, TMO - 1, -1, 23'h0, 0);
    run_req(2'b10, 16'h0200, 23'h7ABCDE, 0, -1, 23'h0, 10);
    run_req(2'b11, 16'h0300, 23'h111111, 0, -1, 23'h0, 2);
    run_req(2'b10, 16'h0400, 23'h222222, 1, 2, 23'h0, 0);
    run_req(2'b00, 16'h0500, 23'h333333, 2, 1, 23'h0, 1);

    // Reset while the DATA transfer is in its ACCESS phase.
    log_q.delete();
    s_xn    = 0;
    g_waits = 0;
    g_err_x = -1;
    g_corr  = '0;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_index = 16'h0600;
    req_data  = 23'h444444;
    @(negedge PCLK);
    req_valid = 1'b0;
    r = 0;
    while (!(PSEL && PENABLE && (PADDR == DAT_A)) && r < 20) begin
      @(negedge PCLK);
      r++;
    end
    chk("reach_dat_access", 64'({PSEL, PENABLE, PADDR}), 64'({1'b1, 1'b1, DAT_A}));
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", 64'({PSEL, PENABLE}), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    n_rsp = 0;
    repeat (8) begin
      @(negedge PCLK);
      if (rsp_valid) n_rsp++;
    end
    chk("rst_mid_no_rsp", 64'(n_rsp), 64'd0);
    chk("rst_mid_req_ready_back", 64'(req_ready), 64'd1);
    chk("rst_mid_no_commit", 64'(s_mem.exists(32'h0600)), 64'd0);

    // Randomized requests over a small set of indices so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      waits = (r < 6) ? 0 : (r < 8) ? $urandom_range(1, 2) : (r == 8) ? TMO - 1 : TMO;
      err_x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      corr  = ((op == 2'b10) && ($urandom_range(0, 3) == 0)) ? 23'($urandom_range(1, 255)) : 23'h0;
      run_req(op, 16'hA500 | 16'($urandom_range(0, 7)), 23'($urandom), waits, err_x, corr,
              $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
